// File: rtl/encoder_8to3_serializer.sv
`timescale 1ns/1ps
// Accepts a multi-hot request vector and emits the index of each set bit, one per
// output handshake, in priority order. First index one cycle after accept; holds under out_ready=0.
module encoder_8to3_serializer #(
  parameter int IN_W         = 8,
  parameter int IDX_W        = 3,
  parameter bit PRIORITY_LSB = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] Y_encoder,
  output logic             out_last,
  output logic             err_zero,
  output logic             busy
);

  if ((IDX_W != $clog2(IN_W)) || (IN_W < 2) || ((IN_W & (IN_W - 1)) != 0)) begin : g_bad_params
    $error("IN_W must be a power of 2 (>= 2) and IDX_W must equal clog2(IN_W)");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e            state_q;
  logic [IN_W-1:0]   pending_q;
  logic [IN_W-1:0]   pending_d;
  logic [IN_W-1:0]   emit_mask;
  logic [IDX_W-1:0]  idx;
  logic              err_q;

  // Priority scan: the last match in loop order wins.
  always_comb begin
    idx = '0;
    if (PRIORITY_LSB) begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (pending_q[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (pending_q[i]) idx = IDX_W'(i);
      end
    end
  end

  assign emit_mask = {{(IN_W-1){1'b0}}, 1'b1} << idx;
  assign pending_d = pending_q & ~emit_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_e != '0) begin
              pending_q <= in_e;
              state_q   <= SERVE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (out_ready) begin
            pending_q <= pending_d;
            if (pending_d == '0) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs derive from registered state only, so reset drops them at once.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SERVE);
  assign busy      = (state_q == SERVE);
  assign Y_encoder = idx;
  assign out_last  = (state_q == SERVE) && (pending_d == '0);
  assign err_zero  = err_q;

endmodule
